// File: rtl/camera_threshold_packer.sv
// OV7670 luma capture: decimate, threshold to one bit per kept pixel, pack the
// bits into line-aligned words with sof/eol/eof flags and queue them in a FIFO.
module camera_threshold_packer #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int LUMA_PHASE      = 1,
    parameter int H_DECIM         = 8,
    parameter int V_DECIM         = 8,
    parameter int OUT_W           = 80,
    parameter int OUT_H           = 60,
    parameter int PACK_W          = 16,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic              cam_pclk,
    input  logic              nreset,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic [7:0]        threshold,
    input  logic              invert,
    output logic [PACK_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              in_frame,
    output logic              frame_done,
    output logic              overflow,
    input  logic              clear_overflow
);

    localparam int PHW = $clog2(BYTES_PER_PIXEL + 1);
    localparam int HPW = $clog2(H_DECIM + 1);
    localparam int VPW = $clog2(V_DECIM + 1);
    localparam int KCW = $clog2(OUT_W + 1);
    localparam int KLW = $clog2(OUT_H + 1);
    localparam int BCW = $clog2(PACK_W + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = PACK_W + 3;

    localparam logic [PHW-1:0] PH_LAST = PHW'(BYTES_PER_PIXEL - 1);
    localparam logic [PHW-1:0] PH_LUMA = PHW'(LUMA_PHASE);
    localparam logic [HPW-1:0] H_LAST  = HPW'(H_DECIM - 1);
    localparam logic [VPW-1:0] V_LAST  = VPW'(V_DECIM - 1);
    localparam logic [KCW-1:0] KC_MAX  = KCW'(OUT_W);
    localparam logic [KCW-1:0] KC_LAST = KCW'(OUT_W - 1);
    localparam logic [KLW-1:0] KL_MAX  = KLW'(OUT_H);
    localparam logic [KLW-1:0] KL_LAST = KLW'(OUT_H - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(PACK_W - 1);
    localparam logic [AW:0]    DEPTH   = (AW + 1)'(FIFO_DEPTH);

    // Stage 1: input registers plus one-cycle history for edge detection.
    logic       vs1, hr1, vs_prev, hr_prev, armed;
    logic [7:0] d1;

    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            vs1     <= 1'b1;
            hr1     <= 1'b0;
            d1      <= 8'd0;
            vs_prev <= 1'b1;
            hr_prev <= 1'b0;
            armed   <= 1'b0;
        end else begin
            vs1     <= cam_vsync;
            hr1     <= cam_href;
            d1      <= cam_data;
            vs_prev <= vs1;
            hr_prev <= hr1;
            // A frame already running at reset release must see vsync idle first.
            armed   <= armed | cam_vsync;
        end
    end

    logic [PHW-1:0]    phase;
    logic [HPW-1:0]    h_phase;
    logic [VPW-1:0]    v_phase;
    logic [KCW-1:0]    kcol;
    logic [KLW-1:0]    kline;
    logic [BCW-1:0]    bit_cnt;
    logic [PACK_W-1:0] pack;
    logic [PACK_W-1:0] new_pack;
    logic              sof_pending;
    logic              push_v;
    logic [EW-1:0]     push_word;

    logic frame_start, frame_end, href_fall, pixel_done;
    logic line_keep, col_keep, kept, luma_bit, last_line, eol_full;

    assign frame_start = armed & vs_prev & ~vs1;
    assign frame_end   = in_frame & vs1 & ~vs_prev;
    assign href_fall   = hr_prev & ~hr1;
    assign pixel_done  = hr1 & (phase == PH_LUMA);
    assign line_keep   = (v_phase == '0) & (kline < KL_MAX);
    assign col_keep    = (h_phase == '0) & (kcol < KC_MAX);
    assign kept        = in_frame & pixel_done & col_keep & line_keep & ~frame_end;
    assign luma_bit    = invert ? (d1 >= threshold) : (d1 < threshold);
    assign last_line   = (kline == KL_LAST);
    assign eol_full    = (kcol == KC_LAST);
    assign new_pack    = pack | ({{(PACK_W-1){1'b0}}, luma_bit} << bit_cnt);

    // Byte phase and column position restart whenever href is low.
    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            phase   <= '0;
            h_phase <= '0;
            kcol    <= '0;
        end else if (!hr1 || frame_start) begin
            phase   <= '0;
            h_phase <= '0;
            kcol    <= '0;
        end else begin
            phase <= (phase == PH_LAST) ? '0 : phase + PHW'(1);
            if (pixel_done) begin
                h_phase <= (h_phase == H_LAST) ? '0 : h_phase + HPW'(1);
                if (col_keep)
                    kcol <= kcol + KCW'(1);
            end
        end
    end

    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            v_phase <= '0;
            kline   <= '0;
        end else if (frame_start) begin
            v_phase <= '0;
            kline   <= '0;
        end else if (in_frame && href_fall) begin
            v_phase <= (v_phase == V_LAST) ? '0 : v_phase + VPW'(1);
            if (line_keep)
                kline <= kline + KLW'(1);
        end
    end

    // Stage 2: pack bits; a finished word is registered and written next cycle.
    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            in_frame    <= 1'b0;
            frame_done  <= 1'b0;
            sof_pending <= 1'b0;
            pack        <= '0;
            bit_cnt     <= '0;
            push_v      <= 1'b0;
            push_word   <= '0;
        end else begin
            frame_done <= 1'b0;
            push_v     <= 1'b0;
            if (frame_start) begin
                in_frame    <= 1'b1;
                sof_pending <= 1'b1;
                pack        <= '0;
                bit_cnt     <= '0;
            end else if (frame_end) begin
                in_frame   <= 1'b0;
                frame_done <= 1'b1;
                pack       <= '0;
                bit_cnt    <= '0;
            end else if (kept) begin
                if (bit_cnt == BC_LAST) begin
                    push_v      <= 1'b1;
                    push_word   <= {sof_pending, eol_full, eol_full & last_line, new_pack};
                    sof_pending <= 1'b0;
                    pack        <= '0;
                    bit_cnt     <= '0;
                end else begin
                    pack    <= new_pack;
                    bit_cnt <= bit_cnt + BCW'(1);
                end
            end else if (in_frame && href_fall && line_keep && bit_cnt != '0) begin
                push_v      <= 1'b1;
                push_word   <= {sof_pending, 1'b1, last_line, pack};
                sof_pending <= 1'b0;
                pack        <= '0;
                bit_cnt     <= '0;
            end
        end
    end

    // Output handshake: a word transfers on any edge where out_valid & out_ready;
    // the head stays unchanged while out_valid is high and out_ready is low.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, push_ok;
    logic [EW-1:0] head;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push_ok   = push_v & ((count < DEPTH) | pop);
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[PACK_W-1:0] : '0;
    assign out_eof   = out_valid & head[PACK_W];
    assign out_eol   = out_valid & head[PACK_W+1];
    assign out_sof   = out_valid & head[PACK_W+2];

    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (push_v && !push_ok)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge cam_pclk) begin
        if (push_ok)
            mem[wr_ptr] <= push_word;
    end

endmodule

// File: tb/tb_camera_threshold_packer.sv
// Bench for camera_threshold_packer: a scaled YUYV instance (a) and a small
// one-byte-per-pixel instance (b), checked through expected-word queues.
module tb_camera_threshold_packer;

    logic clk = 1'b0;
    logic nreset;
    logic [7:0] threshold;
    logic invert;
    logic clear_overflow;

    logic cam_vsync_a, cam_href_a, out_ready_a;
    logic [7:0] cam_data_a;
    logic [15:0] out_data_a;
    logic out_sof_a, out_eol_a, out_eof_a, out_valid_a, in_frame_a, frame_done_a, overflow_a;

    logic cam_vsync_b, cam_href_b, out_ready_b;
    logic [7:0] cam_data_b;
    logic [15:0] out_data_b;
    logic out_sof_b, out_eol_b, out_eof_b, out_valid_b, in_frame_b, frame_done_b, overflow_b;

    int checks = 0;
    int passes = 0;
    int fd_a = 0;
    int fd_b = 0;

    logic [18:0] exp_a_q[$];
    logic [18:0] exp_b_q[$];
    logic [18:0] exp_w;

    logic        stall_watch = 1'b0;
    logic        have_head = 1'b0;
    logic [18:0] head_cap = '0;
    int          stable_err = 0;

    // Clock and reset.
    always #5 clk = ~clk;

    camera_threshold_packer #(
        .BYTES_PER_PIXEL(2), .LUMA_PHASE(1), .H_DECIM(2), .V_DECIM(2),
        .OUT_W(80), .OUT_H(4), .PACK_W(16), .FIFO_DEPTH(16)
    ) dut_a (
        .cam_pclk(clk), .nreset(nreset), .cam_vsync(cam_vsync_a), .cam_href(cam_href_a),
        .cam_data(cam_data_a), .threshold(threshold), .invert(invert),
        .out_data(out_data_a), .out_sof(out_sof_a), .out_eol(out_eol_a), .out_eof(out_eof_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .in_frame(in_frame_a),
        .frame_done(frame_done_a), .overflow(overflow_a), .clear_overflow(clear_overflow)
    );

    camera_threshold_packer #(
        .BYTES_PER_PIXEL(1), .LUMA_PHASE(0), .H_DECIM(1), .V_DECIM(1),
        .OUT_W(20), .OUT_H(2), .PACK_W(16), .FIFO_DEPTH(4)
    ) dut_b (
        .cam_pclk(clk), .nreset(nreset), .cam_vsync(cam_vsync_b), .cam_href(cam_href_b),
        .cam_data(cam_data_b), .threshold(threshold), .invert(invert),
        .out_data(out_data_b), .out_sof(out_sof_b), .out_eol(out_eol_b), .out_eof(out_eof_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .in_frame(in_frame_b),
        .frame_done(frame_done_b), .overflow(overflow_b), .clear_overflow(clear_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitors: pop and compare on every accepted word.
    always @(negedge clk) begin
        if (nreset && out_valid_a && out_ready_a) begin
            if (exp_a_q.size() == 0) begin
                checks++;
                $display("FAIL a_unexpected_word: got 0x%0h, expected no word",
                         {out_sof_a, out_eol_a, out_eof_a, out_data_a});
            end else begin
                exp_w = exp_a_q.pop_front();
                check("a_word", {13'd0, out_sof_a, out_eol_a, out_eof_a, out_data_a}, {13'd0, exp_w});
            end
        end
        if (nreset && out_valid_b && out_ready_b) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                $display("FAIL b_unexpected_word: got 0x%0h, expected no word",
                         {out_sof_b, out_eol_b, out_eof_b, out_data_b});
            end else begin
                exp_w = exp_b_q.pop_front();
                check("b_word", {13'd0, out_sof_b, out_eol_b, out_eof_b, out_data_b}, {13'd0, exp_w});
            end
        end
        if (frame_done_a) fd_a++;
        if (frame_done_b) fd_b++;
        if (stall_watch && out_valid_a) begin
            if (!have_head) begin
                head_cap  = {out_sof_a, out_eol_a, out_eof_a, out_data_a};
                have_head = 1'b1;
            end else if ({out_sof_a, out_eol_a, out_eof_a, out_data_a} != head_cap) begin
                stable_err++;
            end
        end
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Words of a 4-line x 5-word frame on instance a, in order.
    task automatic push_exp_a(input logic [15:0] data, input int n);
        for (int i = 0; i < n; i++)
            exp_a_q.push_back({i == 0, (i % 5) == 4, i == 19, data});
    endtask

    task automatic push_exp_b(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        exp_b_q.push_back({3'b100, w0});
        exp_b_q.push_back({3'b010, w1});
        exp_b_q.push_back({3'b000, w2});
        exp_b_q.push_back({3'b011, w3});
    endtask

    task automatic line_a(input logic [7:0] y, input logic [7:0] c);
        for (int p = 0; p < 168; p++) begin
            for (int b = 0; b < 2; b++) begin
                cam_href_a = 1'b1;
                cam_data_a = (b == 1) ? y : c;
                tick();
            end
        end
        cam_href_a = 1'b0;
        cam_data_a = 8'd0;
        idle(16);
    endtask

    task automatic frame_a(input logic [7:0] y, input logic [7:0] c);
        cam_vsync_a = 1'b1;
        idle(4);
        cam_vsync_a = 1'b0;
        idle(4);
        check("a_in_frame_set", {31'd0, in_frame_a}, 32'd1);
        for (int l = 0; l < 9; l++)
            line_a(y, c);
        idle(8);
        cam_vsync_a = 1'b1;
        idle(8);
    endtask

    task automatic line_b(input logic [7:0] y0, input logic [7:0] y1, input bit lat_chk);
        for (int p = 0; p < 22; p++) begin
            if (lat_chk && p == 17) check("b_latency_not_yet", {31'd0, out_valid_b}, 32'd0);
            if (lat_chk && p == 18) check("b_latency_valid", {31'd0, out_valid_b}, 32'd1);
            cam_href_b = 1'b1;
            cam_data_b = (p % 2 == 0) ? y0 : y1;
            tick();
        end
        cam_href_b = 1'b0;
        cam_data_b = 8'd0;
        idle(8);
    endtask

    task automatic frame_b(input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] b0, input logic [7:0] b1, input bit lat_chk);
        cam_vsync_b = 1'b1;
        idle(4);
        cam_vsync_b = 1'b0;
        idle(4);
        line_b(a0, a1, lat_chk);
        line_b(b0, b1, 1'b0);
        line_b(a0, a1, 1'b0);
        idle(4);
        cam_vsync_b = 1'b1;
        idle(6);
    endtask

    task automatic drain_a(input string name);
        int n = 0;
        while (exp_a_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check(name, exp_a_q.size(), 32'd0);
    endtask

    task automatic drain_b(input string name);
        int n = 0;
        while (exp_b_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check(name, exp_b_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        checks++;
        $display("FAIL timeout: still running at %0t, required to finish earlier", $time);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        int fd0;
        nreset = 1'b0;
        threshold = 8'd120;
        invert = 1'b0;
        clear_overflow = 1'b0;
        cam_vsync_a = 1'b1; cam_href_a = 1'b0; cam_data_a = 8'd0; out_ready_a = 1'b1;
        cam_vsync_b = 1'b1; cam_href_b = 1'b0; cam_data_b = 8'd0; out_ready_b = 1'b1;
        idle(3);
        check("a_reset_outputs", {8'd0, out_valid_a, out_sof_a, out_eol_a, out_eof_a,
              in_frame_a, frame_done_a, overflow_a, 1'b0, out_data_a}, 32'd0);
        check("b_reset_outputs", {8'd0, out_valid_b, out_sof_b, out_eol_b, out_eof_b,
              in_frame_b, frame_done_b, overflow_b, 1'b0, out_data_b}, 32'd0);
        nreset = 1'b1;
        idle(4);

        // Full frame, Y=50 below threshold: every word all ones.
        fd0 = fd_a;
        push_exp_a(16'hFFFF, 20);
        frame_a(8'd50, 8'd200);
        drain_a("a_frame_drain");
        check("a_frame_done_once", fd_a - fd0, 32'd1);
        check("a_in_frame_clear", {31'd0, in_frame_a}, 32'd0);
        check("a_no_overflow", {31'd0, overflow_a}, 32'd0);

        // Consumer stalled for a whole frame: head stable, 16 kept, overflow.
        invert = 1'b1;
        out_ready_a = 1'b0;
        push_exp_a(16'hFFFF, 16);
        stall_watch = 1'b1;
        frame_a(8'd130, 8'd50);
        stall_watch = 1'b0;
        check("c_head_word", {13'd0, head_cap}, {13'd0, 3'b100, 16'hFFFF});
        check("c_head_stable", stable_err, 32'd0);
        check("c_valid_held", {31'd0, out_valid_a}, 32'd1);
        check("c_overflow_set", {31'd0, overflow_a}, 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("c_overflow_cleared", {31'd0, overflow_a}, 32'd0);
        out_ready_a = 1'b1;
        drain_a("c_retained_drain");
        idle(4);
        check("c_fifo_empty", {31'd0, out_valid_a}, 32'd0);

        // vsync rises mid-line after 7 kept pixels: partial word discarded.
        invert = 1'b0;
        fd0 = fd_a;
        cam_vsync_a = 1'b1;
        idle(4);
        cam_vsync_a = 1'b0;
        idle(4);
        for (int p = 0; p < 14; p++) begin
            for (int b = 0; b < 2; b++) begin
                cam_href_a = 1'b1;
                cam_data_a = (b == 1) ? 8'd50 : 8'd200;
                tick();
            end
        end
        cam_vsync_a = 1'b1;
        for (int b = 0; b < 4; b++) begin
            cam_data_a = (b % 2 == 1) ? 8'd50 : 8'd200;
            tick();
        end
        cam_href_a = 1'b0;
        idle(8);
        check("d_in_frame_clear", {31'd0, in_frame_a}, 32'd0);
        check("d_frame_done", fd_a - fd0, 32'd1);
        check("d_no_partial_word", {31'd0, out_valid_a}, 32'd0);
        push_exp_a(16'h0000, 20);
        frame_a(8'd200, 8'd50);
        drain_a("d_next_frame_drain");
        check("d_frame_done_total", fd_a - fd0, 32'd2);

        // Reset mid-frame, released while vsync is still low.
        fd0 = fd_a;
        push_exp_a(16'hFFFF, 5);
        cam_vsync_a = 1'b1;
        idle(4);
        cam_vsync_a = 1'b0;
        idle(4);
        line_a(8'd50, 8'd200);
        line_a(8'd50, 8'd200);
        check("e_pre_reset_drained", exp_a_q.size(), 32'd0);
        nreset = 1'b0;
        idle(3);
        check("e_reset_valid", {31'd0, out_valid_a}, 32'd0);
        check("e_reset_in_frame", {31'd0, in_frame_a}, 32'd0);
        nreset = 1'b1;
        for (int l = 2; l < 9; l++)
            line_a(8'd50, 8'd200);
        check("e_ignored_in_frame", {31'd0, in_frame_a}, 32'd0);
        check("e_ignored_no_words", {31'd0, out_valid_a}, 32'd0);
        cam_vsync_a = 1'b1;
        idle(8);
        check("e_no_frame_done", fd_a - fd0, 32'd0);
        push_exp_a(16'hFFFF, 20);
        frame_a(8'd50, 8'd200);
        drain_a("e_recovered_drain");
        check("e_frame_done_once", fd_a - fd0, 32'd1);

        // Small instance: partial words, threshold equality with both polarities.
        fd0 = fd_b;
        invert = 1'b0;
        push_exp_b(16'hAAAA, 16'h000A, 16'h5555, 16'h0005);
        frame_b(8'd200, 8'd50, 8'd50, 8'd200, 1'b1);
        drain_b("b_alt_drain");
        invert = 1'b1;
        push_exp_b(16'hFFFF, 16'h000F, 16'hFFFF, 16'h000F);
        frame_b(8'd120, 8'd120, 8'd120, 8'd120, 1'b0);
        drain_b("b_eq_invert_drain");
        invert = 1'b0;
        push_exp_b(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        frame_b(8'd120, 8'd120, 8'd120, 8'd120, 1'b0);
        drain_b("b_eq_plain_drain");
        check("b_frame_done_count", fd_b - fd0, 32'd3);
        check("b_no_overflow", {31'd0, overflow_b}, 32'd0);

        idle(4);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
